// File: rtl/tour_cmd_sched.sv
// tour_cmd_sched: host-side command scheduler for the Knight robot.
// Buffers a tour of 16-bit commands in a circular FIFO and issues them one at
// a time to remoteComm, waiting for an acknowledge byte after each command.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_cmd       enqueue a command
//   start, abort        begin/retry a run; flush and stop
//   cmd, send_cmd       command word and one-cycle issue strobe to remoteComm
//   cmd_sent            remoteComm finished transmitting
//   resp_rdy, resp      response byte from the robot
//   busy, done          run in progress; one-cycle pulse when all acked
//   err, err_code       sticky error (1 NAK, 2 timeout, 3 overflow)
//   level, full, empty  FIFO status
//   acked               commands acked since last start (saturating)
module tour_cmd_sched #(
    parameter int          DEPTH      = 8,
    parameter int          TMO_CYCLES = 8000000,
    parameter logic [7:0]  ACK        = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [15:0]              wr_cmd,
    input  logic                     start,
    input  logic                     abort,
    output logic [15:0]              cmd,
    output logic                     send_cmd,
    input  logic                     cmd_sent,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               acked
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TMO_CYCLES) + 1;

    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_SENT, WAIT_RESP, ERR
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic [TW-1:0] tmo;
    logic [15:0]   head_nxt;

    logic push_ok, overflow, pop, ack_ok, nak, tmo_hit, go;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ack_ok    = 1'b0;
        nak       = 1'b0;
        tmo_hit   = 1'b0;
        go        = 1'b0;
        // A push into a full FIFO is dropped even if a pop happens this cycle.
        push_ok   = wr_en && !full && !abort;
        overflow  = wr_en &&  full && !abort;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !empty) begin
                        state_nxt = SEND;
                        go        = 1'b1;
                    end
                end
                SEND: state_nxt = WAIT_SENT;
                WAIT_SENT, WAIT_RESP: begin
                    // A response beats both the timeout and cmd_sent.
                    if (resp_rdy) begin
                        if (resp == ACK) begin
                            pop    = 1'b1;
                            ack_ok = 1'b1;
                            // A push landing on the last pop keeps the run going.
                            state_nxt = (level == LVL_ONE && !push_ok) ? IDLE : SEND;
                        end else begin
                            nak       = 1'b1;
                            state_nxt = ERR;
                        end
                    end else if (tmo == TMO_LAST) begin
                        tmo_hit   = 1'b1;
                        state_nxt = ERR;
                    end else if (state == WAIT_SENT && cmd_sent) begin
                        state_nxt = WAIT_RESP;
                    end
                end
                ERR: begin
                    if (start) begin
                        state_nxt = SEND;
                        go        = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer / level arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        if (abort) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (push_ok) wr_ptr_nxt = wr_ptr + LVL_ONE;
            if (pop)     rd_ptr_nxt = rd_ptr + LVL_ONE;
            if (push_ok && !pop)      level_nxt = level + LVL_ONE;
            else if (!push_ok && pop) level_nxt = level - LVL_ONE;
        end
        // Head after this edge. If the pop empties the FIFO while a push lands
        // in the same cycle, the new head is still on wr_cmd, not in mem.
        if (push_ok && wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])
            head_nxt = wr_cmd;
        else
            head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_cmd;
    end

    // ------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            cmd      <= '0;
            send_cmd <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            acked    <= '0;
            tmo      <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            full     <= (level_nxt == LVL_FULL);
            empty    <= (level_nxt == '0);

            // abort forces IDLE, so the strobe can never fire in an abort cycle.
            send_cmd <= (state_nxt == SEND);
            busy     <= (state_nxt == SEND) || (state_nxt == WAIT_SENT) ||
                        (state_nxt == WAIT_RESP);
            done     <= ack_ok && (state_nxt == IDLE);

            if (state_nxt == SEND) cmd <= head_nxt;

            // Counts cycles since the send strobe: 0 during SEND, so the
            // timeout decision is taken TMO_CYCLES-1 cycles after send_cmd.
            if (state_nxt == SEND)
                tmo <= '0;
            else if (state == SEND || state == WAIT_SENT || state == WAIT_RESP)
                tmo <= tmo + TMO_ONE;

            if (go && state == IDLE)
                acked <= '0;
            else if (ack_ok && acked != 8'hFF)
                acked <= acked + 8'd1;

            if (abort) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end else if (nak) begin
                err      <= 1'b1;
                err_code <= 2'd1;
            end else if (tmo_hit) begin
                err      <= 1'b1;
                err_code <= 2'd2;
            end else if (overflow) begin
                err      <= 1'b1;
                err_code <= 2'd3;
            end else if (go) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_tour_cmd_sched.sv
// tb_tour_cmd_sched: directed, table-driven bench for tour_cmd_sched.
// Each table row is one clock: inputs applied after a falling edge, expected
// outputs checked at the following falling edge. Timeout and asynchronous
// reset are exercised by hand-written sequences after the table.
module tb_tour_cmd_sched;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;

    logic        clk, rst_n;
    logic        wr_en, start, abort, cmd_sent, resp_rdy;
    logic [15:0] wr_cmd, cmd;
    logic [7:0]  resp, acked;
    logic        send_cmd, busy, done, err, full, empty;
    logic [1:0]  err_code;
    logic [3:0]  level;

    tour_cmd_sched #(.DEPTH(DEPTH), .TMO_CYCLES(TMO), .ACK(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd),
        .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .level(level), .full(full), .empty(empty), .acked(acked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [2:0] {NOP, PUSH, START, ABORT, SENT, RESP, PUSHRESP} op_t;

    typedef struct {
        op_t         op;
        logic [15:0] data;
        logic [7:0]  rbyte;
        logic        x_send;
        logic [15:0] x_cmd;
        logic        x_busy;
        logic        x_done;
        logic        x_err;
        logic [1:0]  x_code;
        logic [3:0]  x_level;
        logic [7:0]  x_acked;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input op_t op, input logic [15:0] data, input logic [7:0] rbyte,
                       input logic s, input logic [15:0] c, input logic b, input logic d,
                       input logic e, input logic [1:0] code, input int lvl, input int ack);
        vec_t v;
        v.op = op; v.data = data; v.rbyte = rbyte;
        v.x_send = s; v.x_cmd = c; v.x_busy = b; v.x_done = d; v.x_err = e;
        v.x_code = code; v.x_level = 4'(lvl); v.x_acked = 8'(ack);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en    = (v.op == PUSH) || (v.op == PUSHRESP);
        wr_cmd   = v.data;
        start    = (v.op == START);
        abort    = (v.op == ABORT);
        cmd_sent = (v.op == SENT);
        resp_rdy = (v.op == RESP) || (v.op == PUSHRESP);
        resp     = v.rbyte;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_cmd = '0; start = 0; abort = 0;
        cmd_sent = 0; resp_rdy = 0; resp = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd"},      -1, cmd,      0);
        chk({tag, "_send_cmd"}, -1, send_cmd, 0);
        chk({tag, "_busy"},     -1, busy,     0);
        chk({tag, "_done"},     -1, done,     0);
        chk({tag, "_err"},      -1, err,      0);
        chk({tag, "_err_code"}, -1, err_code, 0);
        chk({tag, "_level"},    -1, level,    0);
        chk({tag, "_empty"},    -1, empty,    1);
        chk({tag, "_full"},     -1, full,     0);
        chk({tag, "_acked"},    -1, acked,    0);
    endtask

    initial begin
        int extra;
        idle_inputs();
        rst_n = 1'b0;

        // ---- three-command tour, all acked; then start on empty FIFO ----
        add(PUSH,  16'h2000, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0);
        add(PUSH,  16'h4001, 0, 0, 16'h0000, 0, 0, 0, 0, 2, 0);
        add(PUSH,  16'h5BF2, 0, 0, 16'h0000, 0, 0, 0, 0, 3, 0);
        add(START, 0, 0,        1, 16'h2000, 1, 0, 0, 0, 3, 0);
        add(NOP,   0, 0,        0, 16'h2000, 1, 0, 0, 0, 3, 0);
        add(SENT,  0, 0,        0, 16'h2000, 1, 0, 0, 0, 3, 0);
        add(RESP,  0, 8'hA5,    1, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(NOP,   0, 0,        0, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(SENT,  0, 0,        0, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(RESP,  0, 8'hA5,    1, 16'h5BF2, 1, 0, 0, 0, 1, 2);
        add(NOP,   0, 0,        0, 16'h5BF2, 1, 0, 0, 0, 1, 2);
        add(RESP,  0, 8'hA5,    0, 16'h5BF2, 0, 1, 0, 0, 0, 3); // ack while still in WAIT_SENT
        add(NOP,   0, 0,        0, 16'h5BF2, 0, 0, 0, 0, 0, 3);
        add(START, 0, 0,        0, 16'h5BF2, 0, 0, 0, 0, 0, 3); // empty: ignored

        // ---- overflow: DEPTH+1 pushes, then drain; 9th is never issued ----
        for (int i = 0; i < DEPTH; i++)
            add(PUSH, 16'h1000 + 16'(i), 0, 0, 16'h5BF2, 0, 0, 0, 0, i + 1, 3);
        add(PUSH,  16'h1008, 0, 0, 16'h5BF2, 0, 0, 1, 3, 8, 3);
        add(START, 0, 0,        1, 16'h1000, 1, 0, 0, 0, 8, 0);
        for (int j = 0; j < DEPTH; j++) begin
            add(NOP, 0, 0, 0, 16'h1000 + 16'(j), 1, 0, 0, 0, 8 - j, j);
            if (j < DEPTH - 1)
                add(RESP, 0, 8'hA5, 1, 16'h1001 + 16'(j), 1, 0, 0, 0, 7 - j, j + 1);
            else
                add(RESP, 0, 8'hA5, 0, 16'h1007, 0, 1, 0, 0, 0, 8);
        end
        add(NOP,   0, 0,        0, 16'h1007, 0, 0, 0, 0, 0, 8);

        // ---- NAK on second command, retry with start ----
        add(PUSH,  16'h2000, 0, 0, 16'h1007, 0, 0, 0, 0, 1, 8);
        add(PUSH,  16'h4001, 0, 0, 16'h1007, 0, 0, 0, 0, 2, 8);
        add(PUSH,  16'h5BF2, 0, 0, 16'h1007, 0, 0, 0, 0, 3, 8);
        add(START, 0, 0,        1, 16'h2000, 1, 0, 0, 0, 3, 0);
        add(NOP,   0, 0,        0, 16'h2000, 1, 0, 0, 0, 3, 0);
        add(RESP,  0, 8'hA5,    1, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(NOP,   0, 0,        0, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(SENT,  0, 0,        0, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(RESP,  0, 8'h5A,    0, 16'h4001, 0, 0, 1, 1, 2, 1);
        add(NOP,   0, 0,        0, 16'h4001, 0, 0, 1, 1, 2, 1);
        add(START, 0, 0,        1, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(NOP,   0, 0,        0, 16'h4001, 1, 0, 0, 0, 2, 1);
        add(RESP,  0, 8'hA5,    1, 16'h5BF2, 1, 0, 0, 0, 1, 2);
        add(NOP,   0, 0,        0, 16'h5BF2, 1, 0, 0, 0, 1, 2);
        add(RESP,  0, 8'hA5,    0, 16'h5BF2, 0, 1, 0, 0, 0, 3);
        add(NOP,   0, 0,        0, 16'h5BF2, 0, 0, 0, 0, 0, 3);

        // ---- push+pop at level 2, then abort in WAIT_RESP ----
        add(PUSH,  16'h0A01, 0, 0, 16'h5BF2, 0, 0, 0, 0, 1, 3);
        add(PUSH,  16'h0A02, 0, 0, 16'h5BF2, 0, 0, 0, 0, 2, 3);
        add(PUSH,  16'h0A03, 0, 0, 16'h5BF2, 0, 0, 0, 0, 3, 3);
        add(START, 0, 0,        1, 16'h0A01, 1, 0, 0, 0, 3, 0);
        add(NOP,   0, 0,        0, 16'h0A01, 1, 0, 0, 0, 3, 0);
        add(RESP,  0, 8'hA5,    1, 16'h0A02, 1, 0, 0, 0, 2, 1);
        add(NOP,   0, 0,        0, 16'h0A02, 1, 0, 0, 0, 2, 1);
        add(PUSHRESP, 16'h0A04, 8'hA5, 1, 16'h0A03, 1, 0, 0, 0, 2, 2);
        add(NOP,   0, 0,        0, 16'h0A03, 1, 0, 0, 0, 2, 2);
        add(SENT,  0, 0,        0, 16'h0A03, 1, 0, 0, 0, 2, 2);
        add(ABORT, 0, 0,        0, 16'h0A03, 0, 0, 0, 0, 0, 2);
        add(NOP,   0, 0,        0, 16'h0A03, 0, 0, 0, 0, 0, 2);

        // ---- push landing on the last pop: new head issued directly ----
        add(PUSH,  16'h0B01, 0, 0, 16'h0A03, 0, 0, 0, 0, 1, 2);
        add(START, 0, 0,        1, 16'h0B01, 1, 0, 0, 0, 1, 0);
        add(NOP,   0, 0,        0, 16'h0B01, 1, 0, 0, 0, 1, 0);
        add(PUSHRESP, 16'h0B02, 8'hA5, 1, 16'h0B02, 1, 0, 0, 0, 1, 1);
        add(NOP,   0, 0,        0, 16'h0B02, 1, 0, 0, 0, 1, 1);
        add(RESP,  0, 8'hA5,    0, 16'h0B02, 0, 1, 0, 0, 0, 2);
        add(NOP,   0, 0,        0, 16'h0B02, 0, 0, 0, 0, 0, 2);

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i]);
            @(negedge clk);
            chk("send_cmd", i, send_cmd, vq[i].x_send);
            chk("cmd",      i, cmd,      vq[i].x_cmd);
            chk("busy",     i, busy,     vq[i].x_busy);
            chk("done",     i, done,     vq[i].x_done);
            chk("err",      i, err,      vq[i].x_err);
            chk("err_code", i, err_code, vq[i].x_code);
            chk("level",    i, level,    vq[i].x_level);
            chk("full",     i, full,     (vq[i].x_level == 4'(DEPTH)));
            chk("empty",    i, empty,    (vq[i].x_level == 4'd0));
            chk("acked",    i, acked,    vq[i].x_acked);
        end
        idle_inputs();

        // ---- timeout: no response at all ----
        wr_en = 1; wr_cmd = 16'h7777;
        @(negedge clk);
        wr_en = 0; start = 1;
        @(negedge clk);
        start = 0;
        chk("tmo_send_cmd", -1, send_cmd, 1);
        chk("tmo_cmd",      -1, cmd,      16'h7777);
        extra = 0;
        for (int n = 1; n <= TMO + 10; n++) begin
            @(negedge clk);
            if (send_cmd) extra++;
            if (n == TMO - 1) chk("tmo_not_yet", n, err_code, 0);
            if (n == TMO) begin
                chk("tmo_err_code", n, err_code, 2);
                chk("tmo_err",      n, err,      1);
                chk("tmo_level",    n, level,    1);
                chk("tmo_busy",     n, busy,     0);
            end
        end
        chk("tmo_no_resend", -1, extra, 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("tmo_abort_level", -1, level, 0);
        chk("tmo_abort_err",   -1, err,   0);

        // ---- asynchronous reset while in WAIT_RESP ----
        wr_en = 1; wr_cmd = 16'h0C01;
        @(negedge clk);
        wr_cmd = 16'h0C02;
        @(negedge clk);
        wr_en = 0; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        cmd_sent = 1;
        @(negedge clk);
        cmd_sent = 0;
        chk("pre_rst_busy",  -1, busy,  1);
        chk("pre_rst_level", -1, level, 2);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("post_rst_send_cmd", -1, send_cmd, 0);
        chk("post_rst_busy",     -1, busy,     0);
        chk("post_rst_empty",    -1, empty,    1);
        @(negedge clk);
        chk("post_rst_send_cmd2", -1, send_cmd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tour_cmd_sched.md
# tour_cmd_sched

Host-side command scheduler for the Knight robot. Buffers a tour of 16-bit commands (calibrate, moves, tour start) and issues them one at a time through the `remoteComm` `cmd`/`send_cmd` interface. After each issue it waits for the robot's 8-bit response, then advances on positive acknowledge (8'hA5). It flags NAK, timeout and overflow conditions. Used in system benches and the host bridge in place of hand-sequenced `send_cmd` pulses.

## Interface
Parameters:
- DEPTH, 8: command FIFO entries (power of 2, ≥2)
- TMO_CYCLES, 8000000: max cycles from `send_cmd` to `resp_rdy`
- ACK, 8'hA5: positive-acknowledge response byte

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- wr_en  in  1  push `wr_cmd` into FIFO
- wr_cmd  in  16  command to enqueue
- start  in  1  begin draining FIFO (one-cycle pulse)
- abort  in  1  stop, flush FIFO, return to IDLE
- cmd  out  16  command to `remoteComm`
- send_cmd  out  1  one-cycle issue strobe to `remoteComm`
- cmd_sent  in  1  `remoteComm` finished transmitting `cmd`
- resp_rdy  in  1  response byte valid (pulse)
- resp  in  8  response byte
- busy  out  1  high in SEND/WAIT_SENT/WAIT_RESP
- done  out  1  one-cycle pulse: FIFO drained, all commands acked
- err  out  1  sticky error, cleared by `start` or `abort`
- err_code  out  2  0 none, 1 NAK, 2 timeout, 3 overflow
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- full / empty  out  1  FIFO status
- acked  out  8  commands acked since last `start` (saturates at 255)

## Operation
- FIFO: circular buffer, separate read/write pointers with an extra wrap bit; `full` = level==DEPTH, `empty` = level==0.
- Push when full: entry dropped; `err`=1, `err_code`=3 (does not stop an active run).
- Push and pop in the same cycle: both occur; `level` unchanged.
- FSM states: IDLE, SEND, WAIT_SENT, WAIT_RESP, ERR.
- IDLE:
  - `start` & !empty → SEND; clears `err`, `err_code`, `acked`.
  - `start` & empty → ignored.
- SEND: `cmd` ← FIFO head, `send_cmd`=1 for this single cycle, timeout counter cleared → WAIT_SENT.
- WAIT_SENT: `cmd_sent` → WAIT_RESP. A `resp_rdy` arriving here is also accepted (same handling as WAIT_RESP).
- WAIT_RESP, on `resp_rdy`:
  - `resp`==ACK: pop head, `acked`++. If FIFO now empty → IDLE with `done` pulse; else → SEND.
  - Any other value: no pop, `err_code`=1 → ERR.
- Timeout: counter increments each cycle in WAIT_SENT/WAIT_RESP. Reaching TMO_CYCLES-1 without `resp_rdy` → ERR, `err_code`=2, no pop. `resp_rdy` in the same cycle wins over timeout.
- ERR: `err`=1; the failing command stays at the FIFO head. `start` → SEND (retry head, clears err); `abort` → IDLE.
- `abort` (any state, highest priority): flush FIFO (pointers to 0), → IDLE, clear `err`. No `done` pulse. `send_cmd` is never asserted in the abort cycle.
- `cmd` holds its value from SEND until the next SEND (stable for `remoteComm` latching).

## Timing
- Reset values: `cmd`=0, `send_cmd`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0, `level`=0, `empty`=1, `full`=0, `acked`=0; FSM in IDLE.
- All outputs are registered.
- `start` sampled at edge k → `send_cmd` high during cycle k+1 only, `cmd` valid from k+1.
- Ack `resp_rdy` at edge m with more queued → next `send_cmd` in cycle m+1.
- Final ack at edge m → `done` high in cycle m+1; `busy` low from m+1.
- `level` reflects a push/pop one cycle after the edge it was sampled on.
- Reset asserted mid-run: immediate return to reset values, FIFO emptied, no residual `send_cmd`.

## Test plan
- Push 16'h2000, 16'h4001, 16'h5BF2; `start`; model acks each with 8'hA5 → three `send_cmd` pulses carrying those values in order, `acked`=3, one `done` pulse, `empty`=1.
- Push DEPTH+1 commands with no start → `full`=1, `level`=8, `err_code`=3; the 9th command is never issued.
- Second response 8'h5A → ERR, `err_code`=1, `level`=2; then `start` with ack → 16'h4001 is re-sent and the run completes.
- TMO_CYCLES=100, no `resp_rdy` → `err_code`=2 exactly 100 cycles after `send_cmd`, and no further `send_cmd`.
- Simultaneous push and ack-pop at level 2 → `level` stays 2. `abort` during WAIT_RESP → IDLE, `level`=0, no `done`.
- `rst_n` low while in WAIT_RESP → all outputs at reset values asynchronously; a later `start` with an empty FIFO is ignored.
